// File: rtl/regfile_mp_pkg.sv
// Shared constants for the multi-ported register file: default geometry and
// the hard-wired zero register index.
package regfile_mp_pkg;

    localparam int DATA_WIDTH_DEF = 64;
    localparam int ADDR_WIDTH_DEF = 5;
    localparam int X0             = 0;

endpackage : regfile_mp_pkg

// File: rtl/regfile_fwd.sv
// One read port's output stage: picks between the array/busy lookup and a
// same-cycle write (wr1 has priority over wr0) when forwarding is enabled.
module regfile_fwd
    import regfile_mp_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int BYPASS     = 1
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] arr_data,
    input  logic                  arr_busy,
    input  logic                  wr0_v,
    input  logic [ADDR_WIDTH-1:0] wr0_addr,
    input  logic [DATA_WIDTH-1:0] wr0_data,
    input  logic                  wr1_v,
    input  logic [ADDR_WIDTH-1:0] wr1_addr,
    input  logic [DATA_WIDTH-1:0] wr1_data,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_busy
);

    // Forward write data and report not-busy when a qualified write hits this port.
    // wrN_v already excludes x0 and reset, so x0 never picks up forwarded data.
    always_comb begin
        rd_data = arr_data;
        rd_busy = arr_busy;
        if (BYPASS != 0) begin
            if (wr1_v && (wr1_addr == addr)) begin
                rd_data = wr1_data;
                rd_busy = 1'b0;
            end else if (wr0_v && (wr0_addr == addr)) begin
                rd_data = wr0_data;
                rd_busy = 1'b0;
            end
        end
    end

endmodule : regfile_fwd

// File: rtl/regfile_mp.sv
// Multi-read, dual-write register file with a per-register pending (busy)
// scoreboard, WAW-stall alloc grant and an incrementally maintained busy count.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int NUM_RD     = 2,
    parameter int BYPASS     = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_RD*ADDR_WIDTH-1:0]   rd_addr,
    output logic [NUM_RD*DATA_WIDTH-1:0]   rd_data,
    output logic [NUM_RD-1:0]              rd_busy,
    input  logic                           wr0_en,
    input  logic [ADDR_WIDTH-1:0]          wr0_addr,
    input  logic [DATA_WIDTH-1:0]          wr0_data,
    input  logic                           wr1_en,
    input  logic [ADDR_WIDTH-1:0]          wr1_addr,
    input  logic [DATA_WIDTH-1:0]          wr1_data,
    input  logic                           alloc_en,
    input  logic [ADDR_WIDTH-1:0]          alloc_addr,
    output logic                           alloc_ok,
    output logic [(2**ADDR_WIDTH)-1:0]     busy_vec,
    output logic [ADDR_WIDTH:0]            busy_count
);

    localparam int                    NUM_REGS = 2 ** ADDR_WIDTH;
    localparam int                    CW       = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] A0       = ADDR_WIDTH'(X0);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [NUM_REGS-1:0]   busy_next;
    logic                  wr0_v, wr1_v, wr_hits_alloc, alloc_set;
    logic                  inc, dec0, dec1;

    // Qualified writes: never to x0, never while reset is held.
    assign wr0_v = reset && wr0_en && (wr0_addr != A0);
    assign wr1_v = reset && wr1_en && (wr1_addr != A0);

    // Grant unless the destination is still pending with no write retiring it now.
    assign wr_hits_alloc = (wr0_v && (wr0_addr == alloc_addr)) ||
                           (wr1_v && (wr1_addr == alloc_addr));
    assign alloc_ok  = (alloc_addr == A0) || !busy_vec[alloc_addr] || wr_hits_alloc;
    assign alloc_set = reset && alloc_en && alloc_ok && (alloc_addr != A0);

    // Count deltas track actual bit transitions; a coincident set beats a clear,
    // and two writes to the same register clear it only once.
    assign inc  = alloc_set && !busy_vec[alloc_addr];
    assign dec0 = wr0_v && busy_vec[wr0_addr] &&
                  !(alloc_set && (alloc_addr == wr0_addr));
    assign dec1 = wr1_v && busy_vec[wr1_addr] &&
                  !(alloc_set && (alloc_addr == wr1_addr)) &&
                  !(wr0_v && (wr0_addr == wr1_addr));

    // Next busy vector: writes clear, alloc sets last so it wins.
    always_comb begin
        busy_next = busy_vec;
        if (wr0_v)     busy_next[wr0_addr]   = 1'b0;
        if (wr1_v)     busy_next[wr1_addr]   = 1'b0;
        if (alloc_set) busy_next[alloc_addr] = 1'b1;
    end

    // Register array; wr1 is applied after wr0 so it wins on an address clash.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
        end else begin
            if (wr0_v) regs[wr0_addr] <= wr0_data;
            if (wr1_v) regs[wr1_addr] <= wr1_data;
        end
    end

    // Busy scoreboard and its running popcount.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_vec   <= '0;
            busy_count <= '0;
        end else begin
            busy_vec   <= busy_next;
            busy_count <= busy_count + CW'(inc) - CW'(dec0) - CW'(dec1);
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_WIDTH-1:0] ra;
        assign ra = rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];

        regfile_fwd #(
            .DATA_WIDTH (DATA_WIDTH),
            .ADDR_WIDTH (ADDR_WIDTH),
            .BYPASS     (BYPASS)
        ) u_fwd (
            .addr     (ra),
            .arr_data (regs[ra]),
            .arr_busy (busy_vec[ra]),
            .wr0_v    (wr0_v),
            .wr0_addr (wr0_addr),
            .wr0_data (wr0_data),
            .wr1_v    (wr1_v),
            .wr1_addr (wr1_addr),
            .wr1_data (wr1_data),
            .rd_data  (rd_data[i*DATA_WIDTH +: DATA_WIDTH]),
            .rd_busy  (rd_busy[i])
        );
    end

endmodule : regfile_mp

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: one forwarding instance and one without,
// sharing all inputs, checked against hand-computed values.
module tb_regfile_mp;

    localparam int DW = 64;
    localparam int AW = 5;
    localparam int NR = 2;

    logic            clk;
    logic            reset;
    logic [AW-1:0]   ra0, ra1;
    logic [NR*AW-1:0] rd_addr;
    logic [NR*DW-1:0] rd_data, rd_data_n;
    logic [NR-1:0]   rd_busy, rd_busy_n;
    logic            wr0_en, wr1_en, alloc_en;
    logic [AW-1:0]   wr0_addr, wr1_addr, alloc_addr;
    logic [DW-1:0]   wr0_data, wr1_data;
    logic            alloc_ok, alloc_ok_n;
    logic [31:0]     busy_vec, busy_vec_n;
    logic [AW:0]     busy_count, busy_count_n;

    int n_cmp = 0;
    int n_bad = 0;

    assign rd_addr = {ra1, ra0};

    regfile_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR), .BYPASS(1)) u_byp (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr), .alloc_ok(alloc_ok),
        .busy_vec(busy_vec), .busy_count(busy_count)
    );

    regfile_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR), .BYPASS(0)) u_nby (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr), .alloc_ok(alloc_ok_n),
        .busy_vec(busy_vec_n), .busy_count(busy_count_n)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        wr0_en = 1'b0; wr1_en = 1'b0; alloc_en = 1'b0;
        wr0_addr = '0; wr1_addr = '0; alloc_addr = '0;
        wr0_data = '0; wr1_data = '0;
    endtask

    // drive phase: just after the falling edge; sample 1 time unit later
    task automatic drive();
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        ra0 = '0; ra1 = '0;
        idle();

        // reset state
        #2;
        chk("rst_count", 64'(busy_count), 64'd0);
        chk("rst_vec", 64'(busy_vec), 64'd0);
        chk("rst_alloc_ok", 64'(alloc_ok), 64'd1);
        drive();
        reset = 1'b1;

        // all registers read 0 after reset
        for (int i = 0; i < 32; i++) begin
            ra0 = AW'(i); ra1 = AW'(31 - i);
            #1;
            chk("init_rd0", rd_data[63:0], 64'd0);
            chk("init_rd1", rd_data[127:64], 64'd0);
        end
        chk("init_count", 64'(busy_count), 64'd0);

        // write x5 with same-cycle read
        drive();
        wr0_en = 1'b1; wr0_addr = 5'd5; wr0_data = 64'h1234; ra0 = 5'd5;
        #1;
        chk("byp_x5", rd_data[63:0], 64'h1234);
        chk("nby_x5", rd_data_n[63:0], 64'h0);
        tick();
        drive();
        idle();
        #1;
        chk("x5_after_byp", rd_data[63:0], 64'h1234);
        chk("x5_after_nby", rd_data_n[63:0], 64'h1234);

        // dual write same address: wr1 wins (also on the forwarding path)
        wr0_en = 1'b1; wr0_addr = 5'd7; wr0_data = 64'hAA;
        wr1_en = 1'b1; wr1_addr = 5'd7; wr1_data = 64'hBB;
        ra1 = 5'd7;
        #1;
        chk("x7_fwd_wr1", rd_data[127:64], 64'hBB);
        tick();
        drive();
        idle();
        #1;
        chk("x7_stored", rd_data[127:64], 64'hBB);
        chk("x7_stored_nby", rd_data_n[127:64], 64'hBB);

        // alloc x3
        alloc_en = 1'b1; alloc_addr = 5'd3; ra0 = 5'd3;
        #1;
        chk("alloc3_ok", 64'(alloc_ok), 64'd1);
        tick();
        chk("alloc3_vec", 64'(busy_vec), 64'h8);
        chk("alloc3_cnt", 64'(busy_count), 64'd1);
        chk("alloc3_rdbusy", 64'(rd_busy[0]), 64'd1);
        // alloc x3 again -> WAW stall
        chk("alloc3_again_ok", 64'(alloc_ok), 64'd0);
        tick();
        chk("alloc3_stall_cnt", 64'(busy_count), 64'd1);
        // write x3 + alloc x3 together: grant, set wins
        drive();
        wr0_en = 1'b1; wr0_addr = 5'd3; wr0_data = 64'h33;
        #1;
        chk("wa3_ok", 64'(alloc_ok), 64'd1);
        chk("wa3_rdbusy_byp", 64'(rd_busy[0]), 64'd0);
        chk("wa3_rdbusy_nby", 64'(rd_busy_n[0]), 64'd1);
        tick();
        chk("wa3_vec", 64'(busy_vec), 64'h8);
        chk("wa3_cnt", 64'(busy_count), 64'd1);
        // plain write clears
        drive();
        idle();
        wr1_en = 1'b1; wr1_addr = 5'd3; wr1_data = 64'h44;
        tick();
        chk("clr3_vec", 64'(busy_vec), 64'h0);
        chk("clr3_cnt", 64'(busy_count), 64'd0);

        // x0: writes ignored, never busy, alloc granted
        drive();
        idle();
        wr0_en = 1'b1; wr0_addr = 5'd0; wr0_data = 64'hFF;
        alloc_en = 1'b1; alloc_addr = 5'd0; ra0 = 5'd0;
        #1;
        chk("x0_ok", 64'(alloc_ok), 64'd1);
        chk("x0_fwd", rd_data[63:0], 64'd0);
        tick();
        drive();
        idle();
        #1;
        chk("x0_rd", rd_data[63:0], 64'd0);
        chk("x0_vec0", 64'(busy_vec[0]), 64'd0);
        chk("x0_cnt", 64'(busy_count), 64'd0);

        // two distinct busy regs cleared in one cycle: 2 -> 0
        alloc_en = 1'b1; alloc_addr = 5'd9;
        tick();
        drive();
        alloc_addr = 5'd10;
        tick();
        chk("two_cnt", 64'(busy_count), 64'd2);
        drive();
        idle();
        wr0_en = 1'b1; wr0_addr = 5'd9;  wr0_data = 64'h9;
        wr1_en = 1'b1; wr1_addr = 5'd10; wr1_data = 64'hA;
        tick();
        chk("two_clr_cnt", 64'(busy_count), 64'd0);
        // both writes on one busy reg clear it only once
        drive();
        idle();
        alloc_en = 1'b1; alloc_addr = 5'd12;
        tick();
        drive();
        idle();
        alloc_en = 1'b1; alloc_addr = 5'd13;
        tick();
        drive();
        idle();
        wr0_en = 1'b1; wr0_addr = 5'd12;
        wr1_en = 1'b1; wr1_addr = 5'd12;
        tick();
        chk("dup_clr_cnt", 64'(busy_count), 64'd1);
        chk("dup_clr_vec", 64'(busy_vec), 64'h2000);
        drive();
        idle();
        wr0_en = 1'b1; wr0_addr = 5'd13;
        tick();
        chk("dup_clr_cnt0", 64'(busy_count), 64'd0);

        // fill x1..x20, then async reset mid-sequence
        for (int i = 1; i <= 20; i++) begin
            drive();
            idle();
            alloc_en = 1'b1; alloc_addr = AW'(i);
            #1;
            chk("fill_ok", 64'(alloc_ok), 64'd1);
            tick();
        end
        chk("fill_cnt", 64'(busy_count), 64'd20);
        chk("fill_vec", 64'(busy_vec), 64'h001F_FFFE);
        drive();
        alloc_addr = 5'd21;
        wr0_en = 1'b1; wr0_addr = 5'd5; wr0_data = 64'h5555;
        ra0 = 5'd5; ra1 = 5'd7;
        #2;
        reset = 1'b0;
        #1;
        chk("arst_cnt", 64'(busy_count), 64'd0);
        chk("arst_vec", 64'(busy_vec), 64'd0);
        chk("arst_rd0", rd_data[63:0], 64'd0);
        chk("arst_rd1", rd_data[127:64], 64'd0);
        chk("arst_ok", 64'(alloc_ok), 64'd1);
        tick();
        chk("rsthold_cnt", 64'(busy_count), 64'd0);
        chk("rsthold_rd0", rd_data_n[63:0], 64'd0);

        // first edge after release behaves normally
        drive();
        reset = 1'b1;
        idle();
        alloc_en = 1'b1; alloc_addr = 5'd4;
        wr0_en = 1'b1; wr0_addr = 5'd6; wr0_data = 64'h66;
        ra0 = 5'd6;
        tick();
        chk("rel_cnt", 64'(busy_count), 64'd1);
        chk("rel_vec", 64'(busy_vec), 64'h10);
        chk("rel_x6", rd_data_n[63:0], 64'h66);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_regfile_mp
